// File: rtl/wb_split_to_if.sv
// Bus bundle between the upstream Wishbone master and the slot fan-out.
// The slave modport is the splitter's view; the master modport is the surrounding SoC.
interface wb_split_to_if #(
  parameter int N  = 7,
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [DW/8-1:0]  m_wmsk;
  logic             m_we;
  logic             m_cyc;
  logic [DW-1:0]    m_rdata;
  logic             m_ack;

  logic [AW-SW-1:0] s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW/8-1:0]  s_wmsk;
  logic             s_we;
  logic [N-1:0]     s_cyc;
  logic [N*DW-1:0]  s_rdata;
  logic [N-1:0]     s_ack;

  modport slave (
    input  m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_rdata, s_ack,
    output m_rdata, m_ack, s_addr, s_wdata, s_wmsk, s_we, s_cyc
  );

  modport master (
    output m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_rdata, s_ack,
    input  m_rdata, m_ack, s_addr, s_wdata, s_wmsk, s_we, s_cyc
  );
endinterface

// File: rtl/wb_split_to.sv
// Wishbone fan-out from one upstream master to N peripheral slots, with registered
// decode/read mux, a per-transaction timeout watchdog and unmapped-slot error responses.
module wb_split_to #(
  parameter int          N        = 7,
  parameter int          AW       = 16,
  parameter int          DW       = 32,
  parameter int          SW       = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_split_to_if.slave  bus,
  output logic          err_stb,
  output logic [SW-1:0] err_slot,
  output logic [15:0]   err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

  logic [1:0]    state;
  logic [SW-1:0] slot;
  logic          err_flag;
  logic [CW-1:0] cnt;

  logic [SW-1:0] req_slot;
  logic [N-1:0]  req_onehot;
  logic          sel_ack;
  logic [DW-1:0] sel_data;
  logic          timeout_hit;
  logic [15:0]   err_cnt_next;

  assign req_slot     = bus.m_addr[AW-1 -: SW];
  assign timeout_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign err_cnt_next = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;

  // Slot decode of the incoming request and ack/data select of the latched slot;
  // an empty one-hot means the request targets an unmapped slot.
  always_comb begin
    req_onehot = '0;
    sel_ack    = 1'b0;
    sel_data   = '0;
    for (int k = 0; k < N; k++) begin
      if (req_slot == SW'(k)) req_onehot[k] = 1'b1;
      if (slot == SW'(k)) begin
        sel_ack  = bus.s_ack[k];
        sel_data = bus.s_rdata[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= '0;
      err_flag    <= 1'b0;
      cnt         <= '0;
      bus.m_ack   <= 1'b0;
      bus.m_rdata <= '0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_wmsk  <= '0;
      bus.s_we    <= 1'b0;
      bus.s_cyc   <= '0;
      err_stb     <= 1'b0;
      err_slot    <= '0;
      err_cnt     <= '0;
    end else begin
      bus.m_ack   <= 1'b0;
      bus.m_rdata <= '0;
      err_stb     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m_cyc) begin
            slot        <= req_slot;
            bus.s_addr  <= bus.m_addr[AW-SW-1:0];
            bus.s_wdata <= bus.m_wdata;
            bus.s_wmsk  <= bus.m_wmsk;
            bus.s_we    <= bus.m_we;
            if (|req_onehot) begin
              bus.s_cyc <= req_onehot;
              cnt       <= '0;
              state     <= ACTIVE;
            end else begin
              err_flag <= 1'b1;
              state    <= RESP;
            end
          end
        end
        ACTIVE: begin
          // A slot ack takes priority over a watchdog expiry in the same cycle.
          if (sel_ack) begin
            bus.s_cyc   <= '0;
            bus.m_ack   <= 1'b1;
            bus.m_rdata <= sel_data;
            state       <= RESP;
          end else if (timeout_hit) begin
            bus.s_cyc   <= '0;
            bus.m_ack   <= 1'b1;
            bus.m_rdata <= ERR_WORD;
            err_stb     <= 1'b1;
            err_slot    <= slot;
            err_cnt     <= err_cnt_next;
            state       <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          // Unmapped requests spend one RESP cycle raising the error completion so
          // their m_ack lands at the same latency as a zero-wait slot.
          if (err_flag) begin
            err_flag    <= 1'b0;
            bus.m_ack   <= 1'b1;
            bus.m_rdata <= ERR_WORD;
            err_stb     <= 1'b1;
            err_slot    <= slot;
            err_cnt     <= err_cnt_next;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_split_to.sv
// Directed self-checking bench for wb_split_to: decode, writes, watchdog, unmapped
// slots, back-to-back transfers and mid-transaction reset.
module tb_wb_split_to;
  localparam int N  = 7;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic        clk;
  logic        rst_n;
  logic        err_stb;
  logic [3:0]  err_slot;
  logic [15:0] err_cnt;

  int errors;
  int checks;

  wb_split_to_if #(.N(N), .AW(AW), .DW(DW), .SW(SW)) bus ();

  wb_split_to #(
    .N(N), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_stb(err_stb),
    .err_slot(err_slot),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wmsk  = '0;
    bus.m_we    = 1'b0;
    bus.m_cyc   = 1'b0;
    bus.s_ack   = '0;
    bus.s_rdata = '0;
  endtask

  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.s_cyc !== 7'b0 || bus.m_ack !== 1'b0 || bus.m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: s_cyc=%b m_ack=%b m_rdata=%h, required 0/0/0", bus.s_cyc, bus.m_ack, bus.m_rdata);
    end
    checks++;
    if (err_stb !== 1'b0 || err_slot !== 4'h0 || err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_err: err_stb=%b err_slot=%h err_cnt=%h, required 0/0/0", err_stb, err_slot, err_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_slot2();
    int high;
    bus.s_rdata[2*DW +: DW] = 32'h12345678;
    bus.m_addr = 16'h2010;
    bus.m_we   = 1'b0;
    bus.m_cyc  = 1'b1;
    high = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.s_cyc === 7'b0000100) high++;
      if (c == 2) bus.s_ack[2] = 1'b1;
    end
    checks++;
    if (high !== 3) begin
      errors++;
      $display("FAIL rd_scyc: s_cyc=0000100 seen %0d cycles, required 3", high);
    end
    checks++;
    if (bus.s_addr !== 12'h010) begin
      errors++;
      $display("FAIL rd_saddr: got %h required 010", bus.s_addr);
    end
    @(negedge clk);
    bus.s_ack = '0;
    checks++;
    if (bus.m_ack !== 1'b1 || bus.m_rdata !== 32'h12345678 || bus.s_cyc !== 7'b0 || err_stb !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack: m_ack=%b m_rdata=%h s_cyc=%b err_stb=%b, required 1/12345678/0/0", bus.m_ack, bus.m_rdata, bus.s_cyc, err_stb);
    end
    bus.m_cyc = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_ack !== 1'b0 || bus.m_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_after: m_ack=%b m_rdata=%h, required 0/0", bus.m_ack, bus.m_rdata);
    end
  endtask

  task automatic test_write_slot5();
    bus.s_rdata[5*DW +: DW] = 32'h0BADF00D;
    bus.m_addr  = 16'h5024;
    bus.m_wdata = 32'hA5A5A5A5;
    bus.m_wmsk  = 4'b0011;
    bus.m_we    = 1'b1;
    bus.m_cyc   = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_cyc !== 7'b0100000 || bus.s_wdata !== 32'hA5A5A5A5 || bus.s_wmsk !== 4'b0011 || bus.s_we !== 1'b1 || bus.s_addr !== 12'h024) begin
      errors++;
      $display("FAIL wr_latch: s_cyc=%b s_wdata=%h s_wmsk=%b s_we=%b s_addr=%h, required 0100000/a5a5a5a5/0011/1/024", bus.s_cyc, bus.s_wdata, bus.s_wmsk, bus.s_we, bus.s_addr);
    end
    bus.s_ack[5] = 1'b1;
    @(negedge clk);
    bus.s_ack = '0;
    checks++;
    if (bus.m_ack !== 1'b1 || bus.m_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL wr_ack: m_ack=%b m_rdata=%h, required 1/0badf00d", bus.m_ack, bus.m_rdata);
    end
    bus.m_cyc = 1'b0;
    bus.m_we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int high;
    bit done;
    bus.m_addr = 16'h1000;
    bus.m_cyc  = 1'b1;
    high = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.m_ack === 1'b1) done = 1'b1;
      else if (bus.s_cyc[1] === 1'b1) high++;
    end
    checks++;
    if (!done || high !== 8) begin
      errors++;
      $display("FAIL to_len: acked=%0d s_cyc[1] high %0d cycles, required acked=1 and 8 cycles", done, high);
    end
    checks++;
    if (bus.m_rdata !== 32'hDEADBEEF || err_stb !== 1'b1 || err_slot !== 4'd1 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL to_err: m_rdata=%h err_stb=%b err_slot=%0d err_cnt=%0d, required deadbeef/1/1/1", bus.m_rdata, err_stb, err_slot, err_cnt);
    end
    bus.m_cyc = 1'b0;
    repeat (2) @(negedge clk);
    bus.s_ack[1] = 1'b1;
    @(negedge clk);
    bus.s_ack = '0;
    checks++;
    if (bus.m_ack !== 1'b0 || err_stb !== 1'b0 || err_cnt !== 16'd1 || bus.s_cyc !== 7'b0) begin
      errors++;
      $display("FAIL to_late_ack: m_ack=%b err_stb=%b err_cnt=%0d s_cyc=%b, required 0/0/1/0", bus.m_ack, err_stb, err_cnt, bus.s_cyc);
    end
  endtask

  task automatic test_unmapped();
    bus.m_addr = 16'hF000;
    bus.m_cyc  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_cyc !== 7'b0 || bus.m_ack !== 1'b0) begin
      errors++;
      $display("FAIL um_first: s_cyc=%b m_ack=%b, required 0/0", bus.s_cyc, bus.m_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.m_ack !== 1'b1 || bus.m_rdata !== 32'hDEADBEEF || err_stb !== 1'b1 || err_slot !== 4'd15 || err_cnt !== 16'd2 || bus.s_cyc !== 7'b0) begin
      errors++;
      $display("FAIL um_ack: m_ack=%b m_rdata=%h err_stb=%b err_slot=%0d err_cnt=%0d s_cyc=%b, required 1/deadbeef/1/15/2/0", bus.m_ack, bus.m_rdata, err_stb, err_slot, err_cnt, bus.s_cyc);
    end
    bus.m_cyc = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_ack !== 1'b0 || err_stb !== 1'b0 || err_slot !== 4'd15) begin
      errors++;
      $display("FAIL um_after: m_ack=%b err_stb=%b err_slot=%0d, required 0/0/15", bus.m_ack, err_stb, err_slot);
    end
  endtask

  task automatic test_back_to_back();
    bus.s_rdata[0*DW +: DW] = 32'h00000A0A;
    bus.s_rdata[3*DW +: DW] = 32'h33333333;
    bus.s_rdata[6*DW +: DW] = 32'h66666666;
    bus.m_addr = 16'h0004;
    bus.m_cyc  = 1'b1;
    @(negedge clk);
    bus.s_ack[3] = 1'b1;
    @(negedge clk);
    bus.s_ack = '0;
    checks++;
    if (bus.s_cyc !== 7'b0000001 || bus.m_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_glitch: s_cyc=%b m_ack=%b, required 0000001/0", bus.s_cyc, bus.m_ack);
    end
    bus.s_ack[0] = 1'b1;
    @(negedge clk);
    bus.s_ack = '0;
    checks++;
    if (bus.m_ack !== 1'b1 || bus.m_rdata !== 32'h00000A0A) begin
      errors++;
      $display("FAIL b2b_first: m_ack=%b m_rdata=%h, required 1/00000a0a", bus.m_ack, bus.m_rdata);
    end
    bus.m_cyc = 1'b0;
    @(negedge clk);
    bus.m_addr = 16'h6008;
    bus.m_cyc  = 1'b1;
    checks++;
    if (bus.s_cyc !== 7'b0 || bus.m_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: s_cyc=%b m_ack=%b, required 0/0", bus.s_cyc, bus.m_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.s_cyc !== 7'b1000000 || bus.s_addr !== 12'h008) begin
      errors++;
      $display("FAIL b2b_second_cyc: s_cyc=%b s_addr=%h, required 1000000/008", bus.s_cyc, bus.s_addr);
    end
    bus.s_ack[6] = 1'b1;
    @(negedge clk);
    bus.s_ack = '0;
    checks++;
    if (bus.m_ack !== 1'b1 || bus.m_rdata !== 32'h66666666) begin
      errors++;
      $display("FAIL b2b_second: m_ack=%b m_rdata=%h, required 1/66666666", bus.m_ack, bus.m_rdata);
    end
    bus.m_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_active();
    bus.s_rdata[4*DW +: DW] = 32'h44440000;
    bus.m_addr = 16'h4000;
    bus.m_cyc  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_cyc !== 7'b0010000) begin
      errors++;
      $display("FAIL rst_active_cyc: s_cyc=%b, required 0010000", bus.s_cyc);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_cyc !== 7'b0 || bus.m_ack !== 1'b0 || err_cnt !== 16'd0 || err_slot !== 4'd0) begin
      errors++;
      $display("FAIL rst_active: s_cyc=%b m_ack=%b err_cnt=%0d err_slot=%0d, required 0/0/0/0", bus.s_cyc, bus.m_ack, err_cnt, err_slot);
    end
    bus.m_cyc = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    bus.m_cyc = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_cyc !== 7'b0010000) begin
      errors++;
      $display("FAIL rst_fresh_cyc: s_cyc=%b, required 0010000", bus.s_cyc);
    end
    bus.s_ack[4] = 1'b1;
    @(negedge clk);
    bus.s_ack = '0;
    checks++;
    if (bus.m_ack !== 1'b1 || bus.m_rdata !== 32'h44440000 || err_stb !== 1'b0) begin
      errors++;
      $display("FAIL rst_fresh_ack: m_ack=%b m_rdata=%h err_stb=%b, required 1/44440000/0", bus.m_ack, bus.m_rdata, err_stb);
    end
    bus.m_cyc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    test_reset();
    test_read_slot2();
    test_write_slot5();
    test_timeout();
    test_unmapped();
    test_back_to_back();
    test_reset_active();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_split_to.md
Name: wb_split_to

Overview:
- Parametrised Wishbone fan-out for the picorv32 SoC peripheral bus: one upstream master port, N downstream peripheral slots.
- Successor to the fixed per-slot cyc/ack/rdata glue in the top level. Adds registered slot decode and a registered read-data mux.
- Adds a per-transaction timeout watchdog that completes hung accesses with an error word.
- Adds unmapped-slot handling, plus an error strobe and a saturating error counter for firmware diagnostics.

Parameters:
N, 7, number of downstream slots (1..16)
AW, 16, upstream address width
DW, 32, data width (multiple of 8)
SW, 4, slot-select bits, taken from m_addr[AW-1 -: SW]; requires 2^SW >= N
TIMEOUT, 255, cycles a slot may hold a transaction before forced completion; 0 disables the watchdog
ERR_DATA, 32'hDEADBEEF, read data returned on timeout or unmapped access (low DW bits used)

Ports:
clk  in  1  system clock (clk_1x domain)
rst_n  in  1  synchronous reset, active-low
m_addr  in  AW  upstream address
m_wdata  in  DW  upstream write data
m_wmsk  in  DW/8  upstream write byte mask
m_we  in  1  upstream write enable
m_cyc  in  1  upstream cycle; held until m_ack
m_rdata  out  DW  read data; zero except in the m_ack cycle
m_ack  out  1  single-cycle completion
s_addr  out  AW-SW  registered low address bits to all slots
s_wdata  out  DW  registered write data
s_wmsk  out  DW/8  registered write mask
s_we  out  1  registered write enable
s_cyc  out  N  one-hot slot cycle
s_rdata  in  N*DW  flat slot read data; slot k at [k*DW +: DW]
s_ack  in  N  slot acks
err_stb  out  1  one-cycle pulse on timeout or unmapped access
err_slot  out  SW  slot index of the last error; held until the next error
err_cnt  out  16  error count; saturates at 16'hFFFF

Behaviour:
- Reset: with rst_n low at a clock edge, all outputs go to 0 and the state goes to IDLE. This applies mid-transaction too: s_cyc drops at that edge, no m_ack is issued, and err_cnt is cleared.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, m_cyc=1 sampled:
  - Latch slot = m_addr[AW-1 -: SW], along with s_addr, s_wdata, s_wmsk, s_we.
  - If slot < N: assert s_cyc[slot] on the next cycle, clear the timeout counter, go to ACTIVE.
  - If slot >= N: assert no s_cyc and go to RESP with the error flag set.
- ACTIVE:
  - s_cyc[slot] stays high. s_ack bits of non-selected slots are ignored.
  - If s_ack[slot]=1: next cycle s_cyc=0, m_ack=1, m_rdata = s_rdata[slot] as registered at the ack edge, go to RESP.
  - Otherwise, if TIMEOUT != 0 and the counter equals TIMEOUT-1: next cycle s_cyc=0, m_ack=1, m_rdata=ERR_DATA, err_stb=1, err_slot=slot, err_cnt += 1 (saturating), go to RESP.
  - A late s_ack arriving after a timeout is ignored.
- RESP:
  - m_ack is high for this one cycle only. For the unmapped case, m_ack and the err_* updates happen in this cycle.
  - Always go to IDLE next. m_cyc is ignored during RESP.
- Latency: a slot that acks combinationally in its first s_cyc cycle gives m_ack 2 cycles after m_cyc is first sampled high. An unmapped access also gives m_ack 2 cycles after m_cyc is sampled.
- Back-to-back: a new m_cyc sampled in IDLE right after RESP is accepted with no bubble beyond the RESP cycle.
- m_rdata is driven to 0 in every cycle where m_ack=0. The same holds for writes: m_rdata is the slot data when a slot acks, and ERR_DATA on error.
- The counter width is sized to hold TIMEOUT. The counter does not run in IDLE or RESP.
- If s_ack and the timeout condition occur in the same cycle, s_ack wins: normal completion, no error.
- Upstream signals other than m_cyc may change only while m_cyc=0. The block uses only its latched copies.

Test Plan:
- Read slot 2 (m_addr=16'h2010), slot acks after 3 cycles with rdata 32'h12345678 -> s_cyc=7'b0000100 for 3 cycles; s_addr=12'h010; m_ack one cycle with m_rdata=32'h12345678; err_stb stays 0.
- Write slot 5, m_wdata=32'hA5A5A5A5, m_wmsk=4'b0011, combinational ack -> s_wdata and s_wmsk match; s_we=1; m_ack 2 cycles after m_cyc is sampled; m_rdata=slot data.
- TIMEOUT=8, slot 1 never acks -> s_cyc[1] high for exactly 8 cycles; m_ack with m_rdata=32'hDEADBEEF; err_stb pulse; err_slot=1; err_cnt=1; an s_ack[1] injected 2 cycles later is ignored.
- Unmapped m_addr=16'hF000 with N=7 -> s_cyc stays 0; m_ack 2 cycles later with ERR_DATA; err_slot=15; err_cnt increments.
- Two back-to-back reads, slot 0 then slot 6, with s_ack[3] glitched during the first -> correct per-slot data; glitch ignored; second s_cyc asserted 1 cycle after the RESP cycle.
- rst_n pulled low while slot 4 is ACTIVE -> s_cyc=0, m_ack=0, err_cnt=0 at the next edge; a fresh read after reset completes normally.
